// File: rtl/axis_packet_arbiter_if.sv
// Bundle of the arbiter's stream signals: NUM_SRC packed slave streams on
// the input side and one merged master stream on the output side.
//   s_axis_tdata  [NUM_SRC*W]  source i in bits [i*W +: W]
//   s_axis_tvalid [NUM_SRC]    per-source valid
//   s_axis_tlast  [NUM_SRC]    per-source last
//   s_axis_tready [NUM_SRC]    per-source ready (from the arbiter)
//   m_axis_tdata  [W]          merged data
//   m_axis_tvalid / tlast      merged valid / last
//   m_axis_tready              downstream ready
//   m_axis_tdest  [DW]         index of the source currently granted
// modport master: the arbiter, which owns the merged output stream.
// modport slave : the environment around it (sources plus downstream sink).
interface axis_packet_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int W       = 8
);
  localparam int DW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic [NUM_SRC-1:0]   s_axis_tready;
  logic [W-1:0]         m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;
  logic [DW-1:0]        m_axis_tdest;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI-Stream output between
// NUM_SRC sources. A grant is held from the first beat to the tlast beat so
// packets never interleave; an optional beat limit (MAX_BEATS) forces tlast
// and releases the grant so a source without tlast cannot lock the output.
// Ports:
//   aclk  in   clock, rising edge
//   rst   in   synchronous reset, active-high; also gates all outputs to 0
//   axis  --   stream bundle (master modport), see axis_packet_arbiter_if
//   busy  out  1 while a source holds the grant
module axis_packet_arbiter #(
  parameter int NUM_SRC            = 2,
  parameter int M_AXIS_TDATA_WIDTH = 8,
  parameter int MAX_BEATS          = 0
) (
  input  logic                         aclk,
  input  logic                         rst,
  axis_packet_arbiter_if.master        axis,
  output logic                         busy
);
  localparam int W  = M_AXIS_TDATA_WIDTH;
  localparam int DW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BW = $clog2(MAX_BEATS) + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state;
  logic [DW-1:0]       r_gnt;
  logic [DW-1:0]       r_last_gnt;
  logic [BW-1:0]       r_beat_cnt;

  logic                w_any;
  logic [DW-1:0]       w_pick;
  logic                w_grant;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [W-1:0]        w_sel_data;
  logic                w_force;
  logic                w_last;
  logic                w_beat;
  logic [NUM_SRC-1:0]  w_tready;

  // Round-robin search starting one past the last winner. Walking the
  // offsets from farthest to nearest lets the nearest requester win.
  always_comb begin
    int idx;
    w_any  = |axis.s_axis_tvalid;
    w_pick = '0;
    idx    = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(r_last_gnt) + k) % NUM_SRC;
      if (axis.s_axis_tvalid[idx]) w_pick = DW'(idx);
    end
  end

  // Mux of the granted source, written as a compare loop so an index never
  // runs past NUM_SRC when it is not a power of two.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_gnt == DW'(i)) begin
        w_sel_valid = axis.s_axis_tvalid[i];
        w_sel_last  = axis.s_axis_tlast[i];
        w_sel_data  = axis.s_axis_tdata[i*W +: W];
      end
    end
  end

  generate
    if (MAX_BEATS != 0) begin : g_limit
      assign w_force = (r_beat_cnt == BW'(MAX_BEATS - 1));
    end else begin : g_nolimit
      assign w_force = 1'b0;
    end
  endgenerate

  // Reset gates every output combinationally, not just the registers.
  assign w_grant = (r_state == S_GRANT) && !rst;
  assign w_last  = w_sel_last | w_force;
  assign w_beat  = w_grant & w_sel_valid & axis.m_axis_tready;

  always_comb begin
    w_tready = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_tready[i] = w_grant && (r_gnt == DW'(i)) && axis.m_axis_tready;
  end

  assign axis.s_axis_tready = w_tready;
  assign axis.m_axis_tvalid = w_grant & w_sel_valid;
  assign axis.m_axis_tdata  = w_grant ? w_sel_data : '0;
  assign axis.m_axis_tlast  = w_grant & w_last;
  assign axis.m_axis_tdest  = w_grant ? r_gnt : '0;
  assign busy               = w_grant;

  // last_gnt resets to the top index so source 0 wins the first round.
  // Leaving GRANT always passes through IDLE: one bubble per packet.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last_gnt <= DW'(NUM_SRC - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            if (w_last) begin
              r_last_gnt <= r_gnt;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter. Two instances share clock/reset:
// if0/u_dut0 has no beat limit, if1/u_dut1 uses MAX_BEATS=5.
// Sources 0,1 feed u_dut0 and 2,3 feed u_dut1. Each source is a tiny model:
// tdata = idx*64 + seq (seq counts accepted beats), tlast on beat len-1 of
// each packet (len=0 means never). Inputs change at posedge+1, outputs are
// checked at posedge+4, handshakes are sampled just before the next edge.
module tb_axis_packet_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy0, busy1;

  always #5 clk = ~clk;

  axis_packet_arbiter_if #(.NUM_SRC(2), .W(8)) if0 ();
  axis_packet_arbiter_if #(.NUM_SRC(2), .W(8)) if1 ();

  axis_packet_arbiter #(.NUM_SRC(2), .M_AXIS_TDATA_WIDTH(8), .MAX_BEATS(0)) u_dut0 (
    .aclk(clk), .rst(rst), .axis(if0.master), .busy(busy0));
  axis_packet_arbiter #(.NUM_SRC(2), .M_AXIS_TDATA_WIDTH(8), .MAX_BEATS(5)) u_dut1 (
    .aclk(clk), .rst(rst), .axis(if1.master), .busy(busy1));

  int total = 0;
  int bad   = 0;

  bit   en   [4];
  bit   hold [4];
  int   len  [4];
  int   cnt  [4];
  int   seq  [4];
  int   beats0;
  logic [1:0] hs0, hs1;

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      int j;
      j = i + 2;
      if0.s_axis_tvalid[i]       = en[i] & ~hold[i];
      if0.s_axis_tdata[i*8 +: 8] = 8'(i*64 + seq[i]);
      if0.s_axis_tlast[i]        = (len[i] != 0) && (cnt[i] == len[i]-1);
      if1.s_axis_tvalid[i]       = en[j] & ~hold[j];
      if1.s_axis_tdata[i*8 +: 8] = 8'(j*64 + seq[j]);
      if1.s_axis_tlast[i]        = (len[j] != 0) && (cnt[j] == len[j]-1);
    end
  endtask

  task automatic adv(input int j);
    seq[j]++;
    if (len[j] != 0 && cnt[j] == len[j]-1) cnt[j] = 0;
    else cnt[j]++;
  endtask

  // Close the current cycle: record handshakes, cross the edge, update sources.
  task automatic cyc();
    hs0 = if0.s_axis_tvalid & if0.s_axis_tready;
    hs1 = if1.s_axis_tvalid & if1.s_axis_tready;
    if (if0.m_axis_tvalid && if0.m_axis_tready) beats0++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs0[i]) adv(i);
      if (hs1[i]) adv(i+2);
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 0; hold[i] = 0; len[i] = 0; cnt[i] = 0; seq[i] = 0;
    end
    beats0 = 0;
    if0.m_axis_tready = 1'b1;
    if1.m_axis_tready = 1'b1;
    drive();
    #1;
    cyc();
    rst = 1'b0;
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) en[i] = 1;
    drive();
    #3;
    total++; if (if0.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid0 got=%b exp=0", if0.m_axis_tvalid); end
    total++; if (if0.s_axis_tready !== 2'b00) begin bad++; $display("FAIL rst_tready0 got=%b exp=00", if0.s_axis_tready); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy0 got=%b exp=0", busy0); end
    total++; if (if0.m_axis_tdest !== 1'b0) begin bad++; $display("FAIL rst_tdest0 got=%b exp=0", if0.m_axis_tdest); end
    total++; if (if0.m_axis_tdata !== 8'h00) begin bad++; $display("FAIL rst_tdata0 got=%h exp=00", if0.m_axis_tdata); end
    total++; if (if0.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast0 got=%b exp=0", if0.m_axis_tlast); end
    total++; if (if1.m_axis_tvalid !== 1'b0 || if1.s_axis_tready !== 2'b00 || busy1 !== 1'b0) begin
      bad++; $display("FAIL rst_dut1 tvalid=%b tready=%b busy=%b exp=0/00/0", if1.m_axis_tvalid, if1.s_axis_tready, busy1);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) en[i] = 0;
    drive();
    #3;
    total++; if (busy0 !== 1'b0 || if0.m_axis_tvalid !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle busy=%b tvalid=%b exp=0/0", busy0, if0.m_axis_tvalid);
    end
  endtask

  // Single 4-beat packet from source 0, source 1 idle.
  task automatic test_single();
    do_reset();
    en[0] = 1; len[0] = 4;
    drive();
    #3;
    total++; if (busy0 !== 1'b0 || if0.s_axis_tready !== 2'b00) begin
      bad++; $display("FAIL single_arb busy=%b tready=%b exp=0/00", busy0, if0.s_axis_tready);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      #3;
      total++; if (if0.m_axis_tvalid !== 1'b1 || busy0 !== 1'b1) begin
        bad++; $display("FAIL single_valid k=%0d tvalid=%b busy=%b exp=1/1", k, if0.m_axis_tvalid, busy0);
      end
      total++; if (if0.m_axis_tdest !== 1'b0) begin bad++; $display("FAIL single_tdest k=%0d got=%b exp=0", k, if0.m_axis_tdest); end
      total++; if (if0.m_axis_tdata !== 8'(k)) begin bad++; $display("FAIL single_tdata k=%0d got=%h exp=%h", k, if0.m_axis_tdata, 8'(k)); end
      total++; if (if0.m_axis_tlast !== (k == 3)) begin bad++; $display("FAIL single_tlast k=%0d got=%b exp=%b", k, if0.m_axis_tlast, k == 3); end
      total++; if (if0.s_axis_tready !== 2'b01) begin bad++; $display("FAIL single_tready k=%0d got=%b exp=01", k, if0.s_axis_tready); end
    end
    cyc();
    en[0] = 0;
    drive();
    #3;
    total++; if (busy0 !== 1'b0 || if0.m_axis_tvalid !== 1'b0) begin
      bad++; $display("FAIL single_after busy=%b tvalid=%b exp=0/0", busy0, if0.m_axis_tvalid);
    end
    total++; if (beats0 !== 4) begin bad++; $display("FAIL single_beats got=%0d exp=4", beats0); end
  endtask

  // Both sources always valid, 3-beat packets: 0,1,0 with one bubble each.
  task automatic test_round_robin();
    do_reset();
    en[0] = 1; en[1] = 1; len[0] = 3; len[1] = 3;
    drive();
    for (int c = 0; c <= 12; c++) begin
      if (c != 0) cyc();
      #3;
      if (c % 4 == 0) begin
        total++; if (busy0 !== 1'b0 || if0.m_axis_tvalid !== 1'b0 || if0.s_axis_tready !== 2'b00) begin
          bad++; $display("FAIL rr_bubble c=%0d busy=%b tvalid=%b tready=%b exp=0/0/00", c, busy0, if0.m_axis_tvalid, if0.s_axis_tready);
        end
      end else begin
        int p, s;
        logic [7:0] d;
        p = c / 4;
        s = p % 2;
        d = 8'(s*64 + (p/2)*3 + (c%4) - 1);
        total++; if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdest !== 1'(s)) begin
          bad++; $display("FAIL rr_dest c=%0d tvalid=%b tdest=%b exp=1/%0d", c, if0.m_axis_tvalid, if0.m_axis_tdest, s);
        end
        total++; if (if0.m_axis_tdata !== d) begin bad++; $display("FAIL rr_tdata c=%0d got=%h exp=%h", c, if0.m_axis_tdata, d); end
        total++; if (if0.m_axis_tlast !== (c % 4 == 3)) begin bad++; $display("FAIL rr_tlast c=%0d got=%b exp=%b", c, if0.m_axis_tlast, c % 4 == 3); end
        total++; if (if0.s_axis_tready !== ((s == 0) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL rr_tready c=%0d got=%b exp=%b", c, if0.s_axis_tready, (s == 0) ? 2'b01 : 2'b10);
        end
      end
    end
  endtask

  // Downstream ready toggles every two cycles in the middle of a packet.
  task automatic test_backpressure();
    int bexp [9] = '{0, 0, 1, 1, 1, 2, 3, 3, 3};
    do_reset();
    en[0] = 1; len[0] = 4;
    drive();
    #3;
    for (int c = 1; c <= 8; c++) begin
      logic rdy;
      cyc();
      rdy = ((c / 2) % 2 == 0);
      if0.m_axis_tready = rdy;
      #3;
      total++; if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdest !== 1'b0) begin
        bad++; $display("FAIL bp_valid c=%0d tvalid=%b tdest=%b exp=1/0", c, if0.m_axis_tvalid, if0.m_axis_tdest);
      end
      total++; if (if0.m_axis_tdata !== 8'(bexp[c])) begin bad++; $display("FAIL bp_tdata c=%0d got=%h exp=%h", c, if0.m_axis_tdata, 8'(bexp[c])); end
      total++; if (if0.m_axis_tlast !== (bexp[c] == 3)) begin bad++; $display("FAIL bp_tlast c=%0d got=%b exp=%b", c, if0.m_axis_tlast, bexp[c] == 3); end
      total++; if (if0.s_axis_tready !== {1'b0, rdy}) begin bad++; $display("FAIL bp_tready c=%0d got=%b exp=0%b", c, if0.s_axis_tready, rdy); end
    end
    cyc();
    if0.m_axis_tready = 1'b1;
    en[0] = 0;
    drive();
    #3;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL bp_after busy=%b exp=0", busy0); end
    total++; if (beats0 !== 4) begin bad++; $display("FAIL bp_beats got=%0d exp=4", beats0); end
  endtask

  // MAX_BEATS=5 instance: source 0 never ends its packet, source 1 waits.
  task automatic test_force_last();
    do_reset();
    en[2] = 1; len[2] = 0;
    en[3] = 1; len[3] = 2;
    drive();
    for (int c = 1; c <= 10; c++) begin
      logic       ebusy, elast, edest;
      logic [7:0] edata;
      cyc();
      #3;
      ebusy = 1; elast = 0; edest = 0; edata = 8'h00;
      if (c <= 5)       begin edata = 8'(128 + c - 1); elast = (c == 5); end
      else if (c == 6)  ebusy = 0;
      else if (c <= 8)  begin edest = 1; edata = 8'(192 + c - 7); elast = (c == 8); end
      else if (c == 9)  ebusy = 0;
      else              edata = 8'(133);
      total++; if (busy1 !== ebusy || if1.m_axis_tvalid !== ebusy) begin
        bad++; $display("FAIL fl_busy c=%0d busy=%b tvalid=%b exp=%b", c, busy1, if1.m_axis_tvalid, ebusy);
      end
      if (ebusy) begin
        total++; if (if1.m_axis_tdest !== edest) begin bad++; $display("FAIL fl_tdest c=%0d got=%b exp=%b", c, if1.m_axis_tdest, edest); end
        total++; if (if1.m_axis_tdata !== edata) begin bad++; $display("FAIL fl_tdata c=%0d got=%h exp=%h", c, if1.m_axis_tdata, edata); end
        total++; if (if1.m_axis_tlast !== elast) begin bad++; $display("FAIL fl_tlast c=%0d got=%b exp=%b", c, if1.m_axis_tlast, elast); end
      end
    end
  endtask

  // One-cycle reset on the second beat of a source-1 packet.
  task automatic test_reset_mid();
    do_reset();
    en[0] = 1; en[1] = 1; len[0] = 4; len[1] = 4;
    drive();
    for (int c = 1; c <= 6; c++) begin
      cyc();
      #3;
    end
    total++; if (if0.m_axis_tdest !== 1'b1 || if0.m_axis_tdata !== 8'd64) begin
      bad++; $display("FAIL rm_pre tdest=%b tdata=%h exp=1/40", if0.m_axis_tdest, if0.m_axis_tdata);
    end
    cyc();
    rst = 1'b1;
    drive();
    #3;
    total++; if (if0.m_axis_tvalid !== 1'b0 || if0.s_axis_tready !== 2'b00 || busy0 !== 1'b0) begin
      bad++; $display("FAIL rm_gate tvalid=%b tready=%b busy=%b exp=0/00/0", if0.m_axis_tvalid, if0.s_axis_tready, busy0);
    end
    total++; if (if0.m_axis_tlast !== 1'b0 || if0.m_axis_tdata !== 8'h00) begin
      bad++; $display("FAIL rm_gate_data tlast=%b tdata=%h exp=0/00", if0.m_axis_tlast, if0.m_axis_tdata);
    end
    cyc();
    rst = 1'b0;
    drive();
    #3;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rm_idle busy=%b exp=0", busy0); end
    cyc();
    #3;
    total++; if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdest !== 1'b0) begin
      bad++; $display("FAIL rm_regrant tvalid=%b tdest=%b exp=1/0", if0.m_axis_tvalid, if0.m_axis_tdest);
    end
    total++; if (if0.m_axis_tdata !== 8'd4) begin bad++; $display("FAIL rm_tdata got=%h exp=04", if0.m_axis_tdata); end
  endtask

  // Granted source 0 drops tvalid for three cycles; grant must be held.
  task automatic test_drop_valid();
    do_reset();
    en[0] = 1; en[1] = 1; len[0] = 4; len[1] = 4;
    drive();
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 3) hold[0] = 1;
      if (c == 6) hold[0] = 0;
      drive();
      #3;
      if (c >= 3 && c <= 5) begin
        total++; if (if0.m_axis_tvalid !== 1'b0 || busy0 !== 1'b1 || if0.m_axis_tdest !== 1'b0) begin
          bad++; $display("FAIL dv_hold c=%0d tvalid=%b busy=%b tdest=%b exp=0/1/0", c, if0.m_axis_tvalid, busy0, if0.m_axis_tdest);
        end
        total++; if (if0.s_axis_tready !== 2'b01) begin bad++; $display("FAIL dv_tready c=%0d got=%b exp=01", c, if0.s_axis_tready); end
      end else if (c == 6 || c == 7) begin
        total++; if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdata !== 8'(c - 4) || if0.m_axis_tlast !== (c == 7)) begin
          bad++; $display("FAIL dv_resume c=%0d tvalid=%b tdata=%h tlast=%b exp=1/%h/%b", c, if0.m_axis_tvalid, if0.m_axis_tdata, if0.m_axis_tlast, 8'(c - 4), c == 7);
        end
      end else if (c == 8) begin
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL dv_bubble busy=%b exp=0", busy0); end
      end else if (c == 9) begin
        total++; if (if0.m_axis_tdest !== 1'b1 || if0.m_axis_tdata !== 8'd64) begin
          bad++; $display("FAIL dv_next tdest=%b tdata=%h exp=1/40", if0.m_axis_tdest, if0.m_axis_tdata);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 0; hold[i] = 0; len[i] = 0; cnt[i] = 0; seq[i] = 0;
    end
    beats0 = 0;
    if0.m_axis_tready = 1'b1;
    if1.m_axis_tready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_force_last();
    test_reset_mid();
    test_drop_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
